// File: rtl/instruction_sequencer_if.sv
// Instruction sequencer bus.
// Groups the program-load, run-control, processor instruction and syscall signals.
//   master: drives loadEnable/loadAddress/loadData/programLength/start/stall/syscallIn,
//           observes operation/nextInstruction/pc/busy/done/syscallValid/syscallData
//   slave : the sequencer itself (opposite directions)
`timescale 1ns/1ps
interface instruction_sequencer_if #(
  parameter int AW = 8
);
  logic          loadEnable;
  logic [AW-1:0] loadAddress;
  logic [31:0]   loadData;
  logic [AW:0]   programLength;
  logic          start;
  logic          stall;
  logic [31:0]   syscallIn;
  logic [1:0]    operation;
  logic [31:0]   nextInstruction;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic          syscallValid;
  logic [31:0]   syscallData;

  modport master (
    output loadEnable, loadAddress, loadData, programLength, start, stall, syscallIn,
    input  operation, nextInstruction, pc, busy, done, syscallValid, syscallData
  );

  modport slave (
    input  loadEnable, loadAddress, loadData, programLength, start, stall, syscallIn,
    output operation, nextInstruction, pc, busy, done, syscallValid, syscallData
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: feeds a Processor from an internal program memory.
// A loaded program is run on start: the CPU is held in reset for RESET_CYCLES,
// then one instruction is issued per cycle (stall inserts no-ops) until the
// program ends. Syscall instructions trigger capture of the CPU's syscallOut.
// Ports:
//   clk, reset : clock shared with the Processor, async active-high reset
//   bus (slave): load port, run control, processor instruction drive, syscall capture
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   IDLE      | waiting for start, CPU sees no-ops
//   CPU_RESET | operation=11 held for RESET_CYCLES cycles
//   RUN       | issuing mem[pc] each non-stalled cycle
//   DONE      | program finished, done=1, pc holds last index
`timescale 1ns/1ps
module instruction_sequencer #(
  parameter int DEPTH        = 256,
  parameter int RESET_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  instruction_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CPU_RESET, RUN, DONE} state_t;

  state_t        state, nextState;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] pc;
  logic [AW:0]   len;
  logic [CW-1:0] resetCount;
  logic          busy, acceptStart, issue, lastIssue, isSyscall, pending;
  logic [1:0]    operation;
  logic [31:0]   nextInstruction;
  logic          syscallValid;
  logic [31:0]   syscallData;

  assign busy        = (state == CPU_RESET) || (state == RUN);
  assign acceptStart = bus.start && !busy;

  // Program memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (bus.loadEnable && !busy) mem[bus.loadAddress] <= bus.loadData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState       = state;
    operation       = 2'b00;
    nextInstruction = '0;
    issue           = 1'b0;
    lastIssue       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) nextState = (bus.programLength == '0) ? DONE : CPU_RESET;
      end
      CPU_RESET: begin
        operation = 2'b11;
        if (resetCount == '0) nextState = RUN;
      end
      RUN: begin
        if (!bus.stall) begin
          operation       = 2'b01;
          nextInstruction = mem[pc];
          issue           = 1'b1;
          if ({1'b0, pc} == len - 1'b1) begin
            lastIssue = 1'b1;
            nextState = DONE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign isSyscall = issue && (nextInstruction[31:26] == 6'd0) && (nextInstruction[5:0] == 6'h0C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= '0;
      len          <= '0;
      resetCount   <= '0;
      pending      <= 1'b0;
      syscallValid <= 1'b0;
      syscallData  <= '0;
    end else begin
      if (acceptStart && bus.programLength != '0) begin
        pc         <= '0;
        len        <= (bus.programLength > DEPTH_LEN) ? DEPTH_LEN : bus.programLength;
        resetCount <= CW'(RESET_CYCLES - 1);
      end else begin
        if (state == CPU_RESET && resetCount != '0) resetCount <= resetCount - 1'b1;
        // The final issue leaves pc on the last index rather than stepping past it.
        if (issue && !lastIssue) pc <= pc + 1'b1;
      end
      // Capture runs one edge behind the issue so the CPU has executed the syscall.
      pending      <= isSyscall;
      syscallValid <= pending;
      if (pending) syscallData <= bus.syscallIn;
    end
  end

  assign bus.operation       = operation;
  assign bus.nextInstruction = nextInstruction;
  assign bus.pc              = pc;
  assign bus.busy            = busy;
  assign bus.done            = (state == DONE);
  assign bus.syscallValid    = syscallValid;
  assign bus.syscallData     = syscallData;
endmodule
